select_segment_param: RTL and testbench
=======================================

Name: select_segment_param

Overview:
- Parametrised successor of the segment selector in the MCMC constraint-solver proposal path.
- Takes one variable's bound pair (greater-than bound, less-than bound) and a mode flag, and builds up to three segments over the signed WIDTH-bit domain: exp-up tail, uniform interior, exp-down tail.
- Draws from an internal 16-bit LFSR and picks one segment with probability proportional to its weight.
- Feeds the value sampler downstream via a start/valid handshake.

Parameters:
- WIDTH, 8: bit width of bounds and segment endpoints (signed, two's complement).
- TAIL_WEIGHT, 16: weight of every non-empty exponential tail segment; must be at least 1.

Ports:
- in_clock  input  1  clock, rising edge.
- in_reset  input  1  synchronous, active-high reset.
- in_enable  input  1  global advance; when 0, FSM, LFSR and all registers hold.
- in_start  input  1  request a selection; sampled only in IDLE with in_enable=1.
- in_seed  input  16  LFSR seed, loaded during reset.
- in_c_less_than  input  WIDTH  signed upper bound hi (x <= hi).
- in_c_more_than  input  WIDTH  signed lower bound lo (x >= lo).
- in_flag  input  2  0 = no constraint, 1 = both bounds, 2 = lower only, 3 = upper only.
- out_busy  output  1  high in every state except IDLE.
- out_valid  output  1  one-cycle pulse when outputs are updated.
- out_chosen_segment_type  output  2  0 = UNIFORM, 1 = EXP_UP, 2 = EXP_DOWN, 3 = NONE.
- out_chosen_segment_from  output  WIDTH  signed segment start, inclusive.
- out_chosen_segment_to  output  WIDTH  signed segment end, inclusive.
- out_chosen_segment_weight  output  WIDTH+1  unsigned weight of the chosen segment.

Behaviour:
- Reset values:
  - FSM goes to IDLE; out_valid=0, out_busy=0.
  - type=3 (NONE), from=0, to=0, weight=0.
  - LFSR loads in_seed; a seed of 0 loads 0x0001 instead.
- Reset mid-operation aborts the run. No out_valid is produced.
- FSM: IDLE -> BUILD -> DRAW -> SELECT -> DONE -> IDLE. Each state advances only on cycles where in_enable=1.
- IDLE: on in_start=1, latch lo, hi and flag, then go to BUILD. in_start outside IDLE is ignored.
- BUILD: compute seg0..seg2 (type, from, to, weight). MIN = -2^(WIDTH-1), MAX = 2^(WIDTH-1)-1.
  - flag 0: seg0 = UNIFORM [MIN, MAX]; seg1 and seg2 are empty.
  - flag 1, lo <= hi: seg0 = EXP_UP [MIN, lo-1]; seg1 = UNIFORM [lo, hi]; seg2 = EXP_DOWN [hi+1, MAX].
  - flag 1, lo > hi (infeasible): mid = (lo+hi)>>>1 computed at WIDTH+1 bits. seg0 = EXP_UP [MIN, mid]; seg1 = EXP_DOWN [mid+1, MAX]; seg2 is empty.
  - flag 2: seg0 = EXP_UP [MIN, lo-1]; seg1 = UNIFORM [lo, MAX]; seg2 is empty.
  - flag 3: seg0 = UNIFORM [MIN, hi]; seg1 = EXP_DOWN [hi+1, MAX]; seg2 is empty.
- Weights:
  - UNIFORM weight = to - from + 1, computed at WIDTH+1 bits unsigned (max 2^WIDTH).
  - Tail weight = TAIL_WEIGHT.
  - An empty segment has weight 0 and type NONE. A tail is empty when lo = MIN (EXP_UP) or hi = MAX (EXP_DOWN); no wrap-around of lo-1 or hi+1 occurs.
  - total = w0 + w1 + w2 at WIDTH+3 bits; total is always > 0.
- DRAW: advance the LFSR once (Galois, right shift): s_next = (s >> 1) ^ (s[0] ? 0xB400 : 0). Then r = (s_next * total) >> 16, so 0 <= r < total.
- SELECT: choose seg0 if r < w0; else seg1 if r < w0+w1; else seg2. Register the chosen type, from, to and weight on the output ports.
- DONE: out_valid=1 for exactly one cycle; outputs hold until the next DONE or reset.
- Latency: start accepted at edge t gives out_valid high after edge t+4 with in_enable held high. Each enable-low cycle adds exactly one cycle.
- The LFSR advances only in DRAW. The random sequence continues across runs and is reset only by in_reset.

Optional Feature:
- Macro: SELECT_SEGMENT_STATS_EN.
- When defined, adds output out_sel_count (48 bits): three 16-bit counters for UNIFORM [15:0], EXP_UP [31:16] and EXP_DOWN [47:32].
  - The matching counter increments in DONE.
  - Counters saturate at 0xFFFF and clear on reset.
- When not defined, the port and the counters are absent; all other behaviour is identical.

Test Plan:
- WIDTH=8, TAIL_WEIGHT=16, seed=0x0001, flag=1, lo=2, hi=10, start -> LFSR = 0xB400, total = 41, r = 28 -> out_valid 4 cycles after start; EXP_DOWN, from 11, to 127, weight 16.
- After reset with seed 0x0001, flag=3, hi=0 -> total = 145, r = 101 -> UNIFORM, from -128, to 0, weight 129.
- After reset with seed 0x0001, flag=1, lo=8, hi=1 (infeasible) -> mid = 4, total = 32, r = 22 -> EXP_DOWN, from 5, to 127, weight 16.
- flag=2, lo=-128, two back-to-back runs -> EXP_UP tail empty; both runs return UNIFORM [-128, 127], weight 256; LFSR reads 0xB400 then 0x5A00.
- Repeat the first scenario with in_enable low for 3 cycles while in DRAW -> out_valid 7 cycles after start; same outputs; in_start during busy is ignored.
- Assert in_reset while in SELECT -> no out_valid; outputs are NONE/0/0/0. The next run reproduces the first scenario's result.

Source files
------------

// File: rtl/select_segment_param.sv
// Segment selector for the MCMC proposal path: bounds -> weighted segment pick.
// Optional selection counters are enabled with SELECT_SEGMENT_STATS_EN.
module select_segment_param #(
  parameter int WIDTH       = 8,
  parameter int TAIL_WEIGHT = 16
) (
  input  logic             in_clock,
  input  logic             in_reset,
  input  logic             in_enable,
  input  logic             in_start,
  input  logic [15:0]      in_seed,
  input  logic [WIDTH-1:0] in_c_less_than,
  input  logic [WIDTH-1:0] in_c_more_than,
  input  logic [1:0]       in_flag,
  output logic             out_busy,
  output logic             out_valid,
  output logic [1:0]       out_chosen_segment_type,
  output logic [WIDTH-1:0] out_chosen_segment_from,
  output logic [WIDTH-1:0] out_chosen_segment_to,
  output logic [WIDTH:0]   out_chosen_segment_weight
`ifdef SELECT_SEGMENT_STATS_EN
  ,
  output logic [47:0]      out_sel_count
`endif
);

  localparam int TW = WIDTH + 3;

  typedef logic signed [WIDTH-1:0] val_t;
  typedef logic [WIDTH:0]          wgt_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BUILD,
    S_DRAW,
    S_SELECT,
    S_DONE
  } state_t;

  localparam logic [1:0] T_UNI  = 2'd0;
  localparam logic [1:0] T_UP   = 2'd1;
  localparam logic [1:0] T_DN   = 2'd2;
  localparam logic [1:0] T_NONE = 2'd3;

  localparam val_t MIN_V  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam val_t MAX_V  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam wgt_t TAIL_W = (WIDTH+1)'(TAIL_WEIGHT);

  state_t        state;
  val_t          lo_q;
  val_t          hi_q;
  logic [1:0]    flag_q;
  logic [1:0]    seg_type [3];
  val_t          seg_from [3];
  val_t          seg_to   [3];
  wgt_t          seg_w    [3];
  logic [TW-1:0] total_q;
  logic [TW-1:0] r_q;
  logic [15:0]   lfsr;

  logic [1:0]    b_type [3];
  val_t          b_from [3];
  val_t          b_to   [3];
  wgt_t          b_w    [3];
  logic [TW-1:0] b_total;

  val_t              lo_m1;
  val_t              hi_p1;
  val_t              mid;
  val_t              mid_p1;
  logic signed [WIDTH:0] sum;
  logic              feas;

  logic [15:0]       lfsr_next;
  logic [WIDTH+18:0] prod;
  logic [TW-1:0]     r_next;

  logic [TW-1:0] w0x;
  logic [TW-1:0] w01x;
  logic [1:0]    c_type;
  val_t          c_from;
  val_t          c_to;
  wgt_t          c_w;

  function automatic wgt_t uni_w(input val_t f, input val_t t);
    wgt_t d;
    d = {t[WIDTH-1], t} - {f[WIDTH-1], f} + wgt_t'(1);
    return d;
  endfunction

  assign out_busy = (state != S_IDLE);

  always_comb begin
    lo_m1  = lo_q - val_t'(1);
    hi_p1  = hi_q + val_t'(1);
    sum    = {lo_q[WIDTH-1], lo_q} + {hi_q[WIDTH-1], hi_q};
    mid    = val_t'(sum >>> 1);
    mid_p1 = mid + val_t'(1);
    feas   = (lo_q <= hi_q);
  end

  // Empty tails stay NONE so lo-1 / hi+1 never wrap into the domain.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      b_type[i] = T_NONE;
      b_from[i] = '0;
      b_to[i]   = '0;
    end
    unique case (1'b1)
      (flag_q == 2'd0): begin
        b_type[0] = T_UNI; b_from[0] = MIN_V; b_to[0] = MAX_V;
      end
      (flag_q == 2'd1) && feas: begin
        if (lo_q != MIN_V) begin
          b_type[0] = T_UP; b_from[0] = MIN_V; b_to[0] = lo_m1;
        end
        b_type[1] = T_UNI; b_from[1] = lo_q; b_to[1] = hi_q;
        if (hi_q != MAX_V) begin
          b_type[2] = T_DN; b_from[2] = hi_p1; b_to[2] = MAX_V;
        end
      end
      (flag_q == 2'd1) && !feas: begin
        b_type[0] = T_UP; b_from[0] = MIN_V;  b_to[0] = mid;
        b_type[1] = T_DN; b_from[1] = mid_p1; b_to[1] = MAX_V;
      end
      (flag_q == 2'd2): begin
        if (lo_q != MIN_V) begin
          b_type[0] = T_UP; b_from[0] = MIN_V; b_to[0] = lo_m1;
        end
        b_type[1] = T_UNI; b_from[1] = lo_q; b_to[1] = MAX_V;
      end
      (flag_q == 2'd3): begin
        b_type[0] = T_UNI; b_from[0] = MIN_V; b_to[0] = hi_q;
        if (hi_q != MAX_V) begin
          b_type[1] = T_DN; b_from[1] = hi_p1; b_to[1] = MAX_V;
        end
      end
      default: ;
    endcase
    for (int i = 0; i < 3; i++) begin
      if (b_type[i] == T_UNI)
        b_w[i] = uni_w(b_from[i], b_to[i]);
      else if (b_type[i] == T_NONE)
        b_w[i] = '0;
      else
        b_w[i] = TAIL_W;
    end
    b_total = TW'(b_w[0]) + TW'(b_w[1]) + TW'(b_w[2]);
  end

  always_comb begin
    lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    prod      = (WIDTH+19)'(lfsr_next) * (WIDTH+19)'(total_q);
    r_next    = TW'(prod >> 16);
  end

  always_comb begin
    w0x    = TW'(seg_w[0]);
    w01x   = w0x + TW'(seg_w[1]);
    c_type = seg_type[2];
    c_from = seg_from[2];
    c_to   = seg_to[2];
    c_w    = seg_w[2];
    unique case (1'b1)
      (r_q < w0x): begin
        c_type = seg_type[0]; c_from = seg_from[0];
        c_to   = seg_to[0];   c_w    = seg_w[0];
      end
      (r_q >= w0x) && (r_q < w01x): begin
        c_type = seg_type[1]; c_from = seg_from[1];
        c_to   = seg_to[1];   c_w    = seg_w[1];
      end
      default: ;
    endcase
  end

  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      state   <= S_IDLE;
      lfsr    <= (in_seed == 16'h0000) ? 16'h0001 : in_seed;
      lo_q    <= '0;
      hi_q    <= '0;
      flag_q  <= '0;
      total_q <= '0;
      r_q     <= '0;
      for (int i = 0; i < 3; i++) begin
        seg_type[i] <= T_NONE;
        seg_from[i] <= '0;
        seg_to[i]   <= '0;
        seg_w[i]    <= '0;
      end
      out_valid                 <= 1'b0;
      out_chosen_segment_type   <= T_NONE;
      out_chosen_segment_from   <= '0;
      out_chosen_segment_to     <= '0;
      out_chosen_segment_weight <= '0;
    end else begin
      out_valid <= in_enable && (state == S_DONE);
      if (in_enable) begin
        unique case (state)
          S_IDLE: begin
            if (in_start) begin
              lo_q   <= in_c_more_than;
              hi_q   <= in_c_less_than;
              flag_q <= in_flag;
              state  <= S_BUILD;
            end
          end
          S_BUILD: begin
            for (int i = 0; i < 3; i++) begin
              seg_type[i] <= b_type[i];
              seg_from[i] <= b_from[i];
              seg_to[i]   <= b_to[i];
              seg_w[i]    <= b_w[i];
            end
            total_q <= b_total;
            state   <= S_DRAW;
          end
          S_DRAW: begin
            lfsr  <= lfsr_next;
            r_q   <= r_next;
            state <= S_SELECT;
          end
          S_SELECT: begin
            out_chosen_segment_type   <= c_type;
            out_chosen_segment_from   <= c_from;
            out_chosen_segment_to     <= c_to;
            out_chosen_segment_weight <= c_w;
            state                     <= S_DONE;
          end
          S_DONE: state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef SELECT_SEGMENT_STATS_EN
  logic [15:0] cnt_uni;
  logic [15:0] cnt_up;
  logic [15:0] cnt_dn;

  assign out_sel_count = {cnt_dn, cnt_up, cnt_uni};

  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      cnt_uni <= '0;
      cnt_up  <= '0;
      cnt_dn  <= '0;
    end else if (in_enable && (state == S_DONE)) begin
      unique case (1'b1)
        (out_chosen_segment_type == T_UNI):
          if (cnt_uni != 16'hFFFF) cnt_uni <= cnt_uni + 16'd1;
        (out_chosen_segment_type == T_UP):
          if (cnt_up != 16'hFFFF) cnt_up <= cnt_up + 16'd1;
        (out_chosen_segment_type == T_DN):
          if (cnt_dn != 16'hFFFF) cnt_dn <= cnt_dn + 16'd1;
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_select_segment_param.sv
// Scoreboard bench for select_segment_param with a segment-list reference model.
module tb_select_segment_param;

  localparam int W    = 8;
  localparam int TWGT = 16;
  localparam int MINV = -(1 << (W-1));
  localparam int MAXV = (1 << (W-1)) - 1;

  logic         clk = 1'b0;
  logic         in_reset = 1'b1;
  logic         in_enable = 1'b1;
  logic         in_start = 1'b0;
  logic [15:0]  in_seed = 16'h0001;
  logic [W-1:0] in_c_less_than = '0;
  logic [W-1:0] in_c_more_than = '0;
  logic [1:0]   in_flag = '0;
  logic         out_busy;
  logic         out_valid;
  logic [1:0]   out_type;
  logic [W-1:0] out_from;
  logic [W-1:0] out_to;
  logic [W:0]   out_weight;

  select_segment_param #(.WIDTH(W), .TAIL_WEIGHT(TWGT)) dut (
    .in_clock                  (clk),
    .in_reset                  (in_reset),
    .in_enable                 (in_enable),
    .in_start                  (in_start),
    .in_seed                   (in_seed),
    .in_c_less_than            (in_c_less_than),
    .in_c_more_than            (in_c_more_than),
    .in_flag                   (in_flag),
    .out_busy                  (out_busy),
    .out_valid                 (out_valid),
    .out_chosen_segment_type   (out_type),
    .out_chosen_segment_from   (out_from),
    .out_chosen_segment_to     (out_to),
    .out_chosen_segment_weight (out_weight)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int typ;
    int from;
    int to;
    int wgt;
    int at;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] m_lfsr = 16'h0001;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Segment list built straight from the bound rules, then a weighted pick.
  function automatic exp_t predict(input int flag, input int lo, input int hi);
    int ty[3];
    int fr[3];
    int tt[3];
    int wt[3];
    longint total;
    longint r;
    longint acc;
    int mid;
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      ty[i] = 3; fr[i] = 0; tt[i] = 0;
    end
    case (flag)
      0: begin ty[0] = 0; fr[0] = MINV; tt[0] = MAXV; end
      1: if (lo <= hi) begin
           if (lo > MINV) begin ty[0] = 1; fr[0] = MINV; tt[0] = lo - 1; end
           ty[1] = 0; fr[1] = lo; tt[1] = hi;
           if (hi < MAXV) begin ty[2] = 2; fr[2] = hi + 1; tt[2] = MAXV; end
         end else begin
           mid = (lo + hi) >>> 1;
           ty[0] = 1; fr[0] = MINV; tt[0] = mid;
           ty[1] = 2; fr[1] = mid + 1; tt[1] = MAXV;
         end
      2: begin
           if (lo > MINV) begin ty[0] = 1; fr[0] = MINV; tt[0] = lo - 1; end
           ty[1] = 0; fr[1] = lo; tt[1] = MAXV;
         end
      default: begin
           ty[0] = 0; fr[0] = MINV; tt[0] = hi;
           if (hi < MAXV) begin ty[1] = 2; fr[1] = hi + 1; tt[1] = MAXV; end
         end
    endcase
    total = 0;
    for (int i = 0; i < 3; i++) begin
      wt[i] = (ty[i] == 0) ? tt[i] - fr[i] + 1 : (ty[i] == 3) ? 0 : TWGT;
      total += wt[i];
    end
    m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    r = (longint'(m_lfsr) * total) >> 16;
    acc = 0;
    e = '{3, 0, 0, 0, 0};
    for (int i = 0; i < 3; i++) begin
      if (e.typ == 3 && wt[i] > 0 && r < acc + wt[i])
        e = '{ty[i], fr[i], tt[i], wt[i], 0};
      acc += wt[i];
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got valid expected none (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("type", int'(out_type), e.typ);
        chk("from", int'($signed(out_from)), e.from);
        chk("to", int'($signed(out_to)), e.to);
        chk("weight", int'(out_weight), e.wgt);
        chk("latency", cyc, e.at);
      end
    end
  end

  task automatic do_reset(input logic [15:0] seed);
    @(negedge clk);
    in_reset = 1'b1;
    in_seed  = seed;
    in_start = 1'b0;
    in_enable = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_type", int'(out_type), 3);
    chk("rst_from", int'(out_from), 0);
    chk("rst_to", int'(out_to), 0);
    chk("rst_weight", int'(out_weight), 0);
    chk("rst_busy", int'(out_busy), 0);
    chk("rst_valid", int'(out_valid), 0);
    in_reset = 1'b0;
    m_lfsr = (seed == 16'h0000) ? 16'h0001 : seed;
  endtask

  task automatic run(input int flag, input int lo, input int hi,
                     input int gap, input bit busy_start);
    exp_t e;
    int t;
    int n;
    @(negedge clk);
    in_flag        = 2'(flag);
    in_c_more_than = W'(lo);
    in_c_less_than = W'(hi);
    in_start       = 1'b1;
    t = cyc + 1;
    e = predict(flag, lo, hi);
    e.at = t + 4 + gap;
    sb.push_back(e);
    @(negedge clk);
    chk("busy", int'(out_busy), 1);
    in_start       = busy_start;
    in_flag        = 2'($urandom_range(0, 3));
    in_c_more_than = W'($urandom);
    in_c_less_than = W'($urandom);
    @(negedge clk);
    in_start = 1'b0;
    if (gap > 0) begin
      in_enable = 1'b0;
      in_start  = busy_start;
      repeat (gap) @(negedge clk);
      in_enable = 1'b1;
      in_start  = 1'b0;
    end
    n = 0;
    while (cyc < e.at && n < 40) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("idle", int'(out_busy), 0);
  endtask

  task automatic run_abort(input int flag, input int lo, input int hi);
    @(negedge clk);
    in_flag        = 2'(flag);
    in_c_more_than = W'(lo);
    in_c_less_than = W'(hi);
    in_start       = 1'b1;
    @(negedge clk);
    in_start = 1'b0;
    repeat (2) @(negedge clk);
    in_reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_type", int'(out_type), 3);
    chk("abort_from", int'(out_from), 0);
    chk("abort_to", int'(out_to), 0);
    chk("abort_weight", int'(out_weight), 0);
    chk("abort_busy", int'(out_busy), 0);
    in_reset = 1'b0;
    m_lfsr = in_seed;
  endtask

  function automatic int pick_val();
    case ($urandom_range(0, 5))
      0: return MINV;
      1: return MAXV;
      2: return MINV + 1;
      3: return MAXV - 1;
      default: return $urandom_range(0, 255) - 128;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset(16'h0001);
    run(1, 2, 10, 0, 1'b0);
    do_reset(16'h0001);
    run(3, 0, 0, 0, 1'b0);
    do_reset(16'h0001);
    run(1, 8, 1, 0, 1'b0);
    do_reset(16'h0001);
    run(2, -128, 0, 0, 1'b0);
    run(2, -128, 0, 0, 1'b0);
    do_reset(16'h0001);
    run(1, 2, 10, 3, 1'b1);
    do_reset(16'h0001);
    run_abort(1, 2, 10);
    run(1, 2, 10, 0, 1'b0);
    do_reset(16'h0000);
    for (int i = 0; i < 40; i++)
      run($urandom_range(0, 3), pick_val(), pick_val(),
          $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    do_reset(16'($urandom_range(1, 65535)));
    for (int i = 0; i < 20; i++)
      run($urandom_range(0, 3), pick_val(), pick_val(), 0, 1'b0);
    repeat (4) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
